// File: rtl/nkmd_dbgbus_pkg.sv
// Shared definitions for the nkmd peripheral-bus arbiter: FSM encoding, park address, debug window.
package nkmd_dbgbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [31:0] PARK_ADDR_DEF = 32'hffff_fff0;
    localparam logic [11:0] DBG_WINDOW    = 12'hc80;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nkmd_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping around.
module nkmd_rr_pick
    import nkmd_dbgbus_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] k;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % NREQ);
            if (!found && req[k]) begin
                found     = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_idx   = k;
            end
        end
    end

endmodule

// File: rtl/nkmd_dbgbus_arb.sv
// Round-robin arbiter serializing NREQ requesters onto the nkmd peripheral bus,
// with short locked bursts and a parked bus between transactions.
module nkmd_dbgbus_arb
    import nkmd_dbgbus_pkg::*;
#(
    parameter int          NREQ      = 2,
    parameter int          LOCK_MAX  = 4,
    parameter logic [31:0] PARK_ADDR = PARK_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ*32-1:0] addr_i,
    input  logic [NREQ*32-1:0] wdata_i,
    input  logic [NREQ-1:0]    we_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [31:0]        rdata_o,
    output logic [31:0]        bus_addr_o,
    output logic [31:0]        bus_data_o,
    output logic               bus_we_o,
    input  logic [31:0]        bus_data_i
);

    localparam int IDX_W = idx_w(NREQ);
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    state_t           state;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             lock_act;
    logic [CNT_W-1:0] lock_cnt;
    logic [31:0]      rdata_q;

    logic [NREQ-1:0]  rr_oh;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] win_idx;
    logic             owner_wins;

    logic [31:0] addr_a  [NREQ];
    logic [31:0] wdata_a [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_a[k]  = addr_i[32*k +: 32];
        assign wdata_a[k] = wdata_i[32*k +: 32];
    end

    nkmd_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr),
        .gnt_oh  (rr_oh),
        .gnt_idx (rr_idx)
    );

    // A live lock only wins while its owner keeps requesting; otherwise plain round-robin.
    assign owner_wins = lock_act && req_i[owner];
    assign win_idx    = owner_wins ? owner : rr_idx;

    // Peripheral data only becomes valid in RESP, so it is passed straight through then.
    assign rdata_o = (state == RESP) ? bus_data_i : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            ptr        <= '0;
            owner      <= '0;
            lock_act   <= 1'b0;
            lock_cnt   <= '0;
            ack_o      <= '0;
            rdata_q    <= '0;
            bus_addr_o <= PARK_ADDR;
            bus_data_o <= '0;
            bus_we_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= '0;
                    if (lock_act && !req_i[owner]) begin
                        lock_act <= 1'b0;
                        lock_cnt <= '0;
                    end
                    if (|rr_oh) begin
                        gnt        <= win_idx;
                        bus_addr_o <= addr_a[win_idx];
                        bus_data_o <= wdata_a[win_idx];
                        bus_we_o   <= we_i[win_idx];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_addr_o <= PARK_ADDR;
                    bus_data_o <= '0;
                    bus_we_o   <= 1'b0;
                    ack_o      <= NREQ'(1) << gnt;
                    state      <= RESP;
                end
                RESP: begin
                    ack_o   <= '0;
                    rdata_q <= bus_data_i;
                    // The pointer only advances when the grant is released.
                    if (lock_i[gnt] && (lock_cnt < CNT_W'(LOCK_MAX - 1))) begin
                        lock_act <= 1'b1;
                        owner    <= gnt;
                        lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        lock_act <= 1'b0;
                        lock_cnt <= '0;
                        ptr      <= (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nkmd_dbgbus_arb.sv
// Directed bench for nkmd_dbgbus_arb with a 16-word register peripheral at 0xc80x.
module tb_nkmd_dbgbus_arb;
    import nkmd_dbgbus_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic        bus_we_o;
    logic [31:0] bus_data_i;

    logic [31:0] mem [16];

    int pass_cnt = 0;
    int total    = 0;

    nkmd_dbgbus_arb #(
        .NREQ     (2),
        .LOCK_MAX (4),
        .PARK_ADDR(32'hffff_fff0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .lock_i     (lock),
        .addr_i     ({addr1, addr0}),
        .wdata_i    ({wd1, wd0}),
        .we_i       (we),
        .ack_o      (ack_o),
        .rdata_o    (rdata_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_we_o   (bus_we_o),
        .bus_data_i (bus_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral: samples address on the edge, returns registered read data the next cycle.
    always @(posedge clk) begin
        if (bus_addr_o[31:4] == {16'h0000, DBG_WINDOW}) begin
            if (bus_we_o) mem[bus_addr_o[3:0]] <= bus_data_o;
            bus_data_i <= mem[bus_addr_o[3:0]];
        end else begin
            bus_data_i <= 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic wait_ack(input logic [1:0] exp, input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack_o == 2'b00 && cyc < 20);
        chk(tag, {30'h0, ack_o}, {30'h0, exp});
    endtask

    initial begin
        int c;
        int ack_seen;
        rst   = 1'b1;
        req   = 2'b11;
        lock  = 2'b00;
        we    = 2'b00;
        addr0 = 32'h0000_c800;
        addr1 = 32'h0000_c801;
        wd0   = 32'h0;
        wd1   = 32'h0;

        // Reset held 3 cycles with both requesting
        tick(); tick(); tick();
        chk("rst_ack",     {30'h0, ack_o}, 32'h0);
        chk("rst_bus_addr", bus_addr_o, 32'hffff_fff0);
        chk("rst_bus_we",  {31'h0, bus_we_o}, 32'h0);
        rst = 1'b0;
        tick();
        chk("first_grant_addr", bus_addr_o, 32'h0000_c800);
        tick();
        chk("first_grant_ack", {30'h0, ack_o}, 32'h1);

        // Contention: alternate 0,1,0,1 at 3-cycle spacing
        wait_ack(2'b10, "cont_ack1", c);
        chk("cont_gap1", c, 3);
        wait_ack(2'b01, "cont_ack0", c);
        chk("cont_gap2", c, 3);
        wait_ack(2'b10, "cont_ack1b", c);
        chk("cont_gap3", c, 3);
        req = 2'b00;
        tick();

        // Single write, cycle-exact
        req = 2'b01; we = 2'b01; addr0 = 32'h0000_c801; wd0 = 32'hdead_beef;
        tick();
        chk("wr_issue_addr", bus_addr_o, 32'h0000_c801);
        chk("wr_issue_data", bus_data_o, 32'hdead_beef);
        chk("wr_issue_we",   {31'h0, bus_we_o}, 32'h1);
        chk("wr_issue_noack", {30'h0, ack_o}, 32'h0);
        tick();
        chk("wr_ack",        {30'h0, ack_o}, 32'h1);
        chk("wr_resp_we",    {31'h0, bus_we_o}, 32'h0);
        chk("wr_resp_park",  bus_addr_o, 32'hffff_fff0);
        req = 2'b00; we = 2'b00;
        tick();
        chk("wr_mem1", mem[1], 32'hdead_beef);

        // Read-back through the window, then a non-window read
        req = 2'b01; we = 2'b01; addr0 = 32'h0000_c802; wd0 = 32'h1234_5678;
        wait_ack(2'b01, "rb_wr_ack", c);
        chk("rb_wr_lat", c, 2);
        req = 2'b00; we = 2'b00;
        tick();
        req = 2'b01;
        wait_ack(2'b01, "rb_rd_ack", c);
        chk("rb_rdata", rdata_o, 32'h1234_5678);
        req = 2'b00;
        tick();
        req = 2'b01; addr0 = 32'h0000_1000;
        wait_ack(2'b01, "nw_rd_ack", c);
        chk("nw_rdata", rdata_o, 32'h0);
        req = 2'b00;
        tick();

        // Locked burst from 1 while 0 waits
        req = 2'b11; lock = 2'b10; we = 2'b10;
        addr0 = 32'h0000_c80f; wd0 = 32'h0;
        addr1 = 32'h0000_c800; wd1 = 32'h1000_0000;
        for (int i = 0; i < 4; i++) begin
            wait_ack(2'b10, $sformatf("lock_ack%0d", i), c);
            addr1 = 32'h0000_c801 + i;
            wd1   = 32'h1000_0001 + i;
        end
        wait_ack(2'b01, "lock_then_req0", c);
        req = 2'b10;
        wait_ack(2'b10, "lock_fifth", c);
        for (int i = 0; i < 5; i++)
            chk($sformatf("lock_mem%0d", i), mem[i], 32'h1000_0000 + i);
        req = 2'b00; lock = 2'b00; we = 2'b00;
        tick();

        // Reset asserted during ISSUE
        req = 2'b01; we = 2'b01; addr0 = 32'h0000_c805; wd0 = 32'h0000_0055;
        tick();
        chk("ri_issue_we", {31'h0, bus_we_o}, 32'h1);
        rst = 1'b1; req = 2'b00; we = 2'b00;
        tick();
        chk("ri_ack",   {30'h0, ack_o}, 32'h0);
        chk("ri_park",  bus_addr_o, 32'hffff_fff0);
        chk("ri_we",    {31'h0, bus_we_o}, 32'h0);
        chk("ri_state", {30'h0, dut.state}, 32'h0);
        chk("ri_ptr",   {31'h0, dut.ptr}, 32'h0);
        rst = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_o != 2'b00) ack_seen++;
        end
        chk("ri_no_ack", ack_seen, 0);
        chk("ri_write_done", mem[5], 32'h0000_0055);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
